// File: rtl/seg_scan_controller.sv
// Scan sequencer for a common-anode multi-digit 7-segment display.
// Each digit slot is BLANK (all anodes off) followed by DRIVE (one anode lit).
// Host frames are double-buffered: a frame is accepted into a shadow buffer
// and copied to the active buffer only on a frame boundary. This keeps a
// frame from changing partway through a scan.
//
// Load handshake: load_ready is high while the shadow buffer is free. A
// frame is accepted on any rising edge where load_valid && load_ready.
// A pending frame is held until it is applied and is never overwritten.
module seg_scan_controller #(
    parameter int DIGITS      = 4,
    parameter int IDX_W       = 2,
    parameter int DIV         = 50000,
    parameter int DIV_W       = 16,
    parameter int BLANK_TICKS = 1,
    parameter int DRIVE_TICKS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_data,
    input  logic [DIGITS-1:0]     load_dp,
    output logic [DIGITS-1:0]     an_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [IDX_W-1:0]      cur_digit,
    output logic                  frame_done,
    output logic [1:0]            o_dbg_state
);

    localparam int PH_MAX = (BLANK_TICKS > DRIVE_TICKS) ? BLANK_TICKS : DRIVE_TICKS;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [DIV_W-1:0] CNT_LAST   = DIV_W'(DIV - 1);
    localparam logic [PH_W-1:0]  BLANK_LAST = PH_W'(BLANK_TICKS - 1);
    localparam logic [PH_W-1:0]  DRIVE_LAST = PH_W'(DRIVE_TICKS - 1);
    localparam logic [IDX_W-1:0] DIGIT_LAST = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    state_t             r_state, w_state_next;
    logic [DIV_W-1:0]   r_cnt, w_cnt_next;
    logic [PH_W-1:0]    r_phase, w_phase_next;
    logic [IDX_W-1:0]   r_digit, w_digit_next;
    logic               w_tick;
    logic               w_boundary;
    logic               w_wrap;

    logic [4*DIGITS-1:0] r_shadow_data, r_active_data;
    logic [DIGITS-1:0]   r_shadow_dp, r_active_dp;
    logic                r_pending;

    logic [3:0]          w_nibble;
    logic                w_dp_sel;
    logic [DIGITS-1:0]   w_an_sel;

    // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        s = 7'h7F;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign w_tick      = (r_cnt == CNT_LAST);
    assign load_ready  = ~r_pending;
    assign cur_digit   = r_digit;
    assign o_dbg_state = r_state;

    // State, prescaler, phase and digit registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OFF;
            r_cnt   <= '0;
            r_phase <= '0;
            r_digit <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_phase <= w_phase_next;
            r_digit <= w_digit_next;
        end
    end

    // Next-state logic; disable overrides everything and parks the scan at digit 0
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_phase_next = r_phase;
        w_digit_next = r_digit;
        w_boundary   = 1'b0;
        w_wrap       = 1'b0;
        if (!enable) begin
            w_state_next = ST_OFF;
            w_cnt_next   = '0;
            w_phase_next = '0;
            w_digit_next = '0;
        end else begin
            case (r_state)
                ST_OFF: begin
                    w_state_next = ST_BLANK;
                    w_cnt_next   = '0;
                    w_phase_next = '0;
                    w_digit_next = '0;
                    w_boundary   = 1'b1;
                end
                ST_BLANK: begin
                    w_cnt_next = w_tick ? '0 : r_cnt + 1'b1;
                    if (w_tick) begin
                        if (r_phase == BLANK_LAST) begin
                            w_state_next = ST_DRIVE;
                            w_phase_next = '0;
                        end else begin
                            w_phase_next = r_phase + 1'b1;
                        end
                    end
                end
                ST_DRIVE: begin
                    w_cnt_next = w_tick ? '0 : r_cnt + 1'b1;
                    if (w_tick) begin
                        if (r_phase == DRIVE_LAST) begin
                            w_state_next = ST_BLANK;
                            w_phase_next = '0;
                            if (r_digit == DIGIT_LAST) begin
                                w_digit_next = '0;
                                w_boundary   = 1'b1;
                                w_wrap       = 1'b1;
                            end else begin
                                w_digit_next = r_digit + 1'b1;
                            end
                        end else begin
                            w_phase_next = r_phase + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_next = ST_OFF;
                    w_cnt_next   = '0;
                    w_phase_next = '0;
                    w_digit_next = '0;
                end
            endcase
        end
    end

    // Select the nibble, decimal point and anode of the digit about to be shown
    always_comb begin
        w_nibble = '0;
        w_dp_sel = 1'b0;
        w_an_sel = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_digit_next == IDX_W'(k)) begin
                w_nibble    = r_active_data[4*k +: 4];
                w_dp_sel    = r_active_dp[k];
                w_an_sel[k] = 1'b0;
            end
        end
    end

    // Shadow/active frame buffers; boundary copy and host accept are exclusive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_data <= '0;
            r_shadow_dp   <= '0;
            r_active_data <= '0;
            r_active_dp   <= '0;
            r_pending     <= 1'b0;
        end else if (w_boundary && r_pending) begin
            r_active_data <= r_shadow_data;
            r_active_dp   <= r_shadow_dp;
            r_pending     <= 1'b0;
        end else if (load_valid && !r_pending) begin
            r_shadow_data <= load_data;
            r_shadow_dp   <= load_dp;
            r_pending     <= 1'b1;
        end
    end

    // Display outputs follow the next state so anode and segments switch together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n       <= '1;
            seg_n      <= 7'h7F;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= w_wrap;
            if (w_state_next == ST_DRIVE) begin
                an_n  <= w_an_sel;
                seg_n <= hex_to_seg(w_nibble);
                dp_n  <= ~w_dp_sel;
            end else begin
                an_n  <= '1;
                seg_n <= 7'h7F;
                dp_n  <= 1'b1;
            end
        end
    end

endmodule
